// File: rtl/mmio_xbar_if.sv
// Memory-mapped request/response bundle with N request lanes sharing one set of request fields.
// N=1 models a CPU port; N=NUM_SLV models the fan-out side of the crossbar.
interface mmio_xbar_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic [TAG_W-1:0]    req_tag;
  logic [N-1:0]        resp_valid;
  logic [N-1:0]        resp_ready;
  logic [N*DATA_W-1:0] resp_rdata;
  logic [N*TAG_W-1:0]  resp_tag;
  logic [N-1:0]        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, req_tag, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_tag, resp_err
  );
endinterface

// File: rtl/mmio_xbar.sv
// One CPU master to NUM_SLV memory-mapped slaves: requests pass straight through to the
// decoded slave, responses are round-robin arbitrated into a single output register.
module mmio_xbar #(
  parameter int NUM_SLV   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int MAX_OUTST = 8,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic        clk,
  input  logic        rst,
  mmio_xbar_if.slave  cpu,
  mmio_xbar_if.master slv
);
  localparam int NCAND = NUM_SLV + 1;
  localparam int RR_W  = $clog2(NCAND);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [RR_W-1:0]  ERR_IDX = RR_W'(NUM_SLV);

  logic                run_q;
  logic                active;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic                err_full_q, err_full_d;
  logic [TAG_W-1:0]    err_tag_q, err_tag_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [TAG_W-1:0]    resp_tag_q, resp_tag_d;
  logic                resp_err_q, resp_err_d;

  logic [NUM_SLV-1:0]  win_hit, hit_oh, s_req_valid, is_store;
  logic                hit_any, room, req_ready, req_hs, resp_hs;
  logic [NCAND-1:0]    cand, gnt_oh;
  logic                gnt_any, can_load;
  logic [RR_W-1:0]     gnt_idx;
  int                  arb_idx;
  logic [DATA_W-1:0]   sel_rdata;
  logic [TAG_W-1:0]    sel_tag;
  logic                sel_err;

  // Everything is held off during reset and for the first cycle after it, so stale
  // slave responses cannot slip in while the slaves come out of reset.
  assign active = run_q & ~rst;
  assign room   = active & (cnt_q < CNT_MAX);

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_win
    assign win_hit[gi] = (cpu.req_addr & SLV_MASK[gi]) == SLV_BASE[gi];
  end

  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (win_hit[i] && !hit_any) begin
        hit_oh[i] = 1'b1;
        hit_any   = 1'b1;
      end
    end
  end

  assign s_req_valid = {NUM_SLV{cpu.req_valid[0] & room}} & hit_oh;
  assign req_ready   = hit_any ? ((|(slv.req_ready & hit_oh)) & room) : (room & ~err_full_q);
  assign req_hs      = cpu.req_valid[0] & req_ready;
  assign resp_hs     = resp_valid_q & cpu.resp_ready[0];

  assign cpu.req_ready = req_ready;
  assign slv.req_valid = s_req_valid;
  assign slv.req_we    = cpu.req_we;
  assign slv.req_addr  = cpu.req_addr;
  assign slv.req_wdata = cpu.req_wdata;
  assign slv.req_wstrb = cpu.req_wstrb;
  assign slv.req_tag   = cpu.req_tag;

  // Per-slave record of load/store, in issue order, so store responses return zero data.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_kind
    logic [MAX_OUTST-1:0] we_q;
    logic [PW-1:0]        wp_q, rp_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
      if (rst) begin
        we_q <= '0;
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (s_req_valid[gi] && slv.req_ready[gi]) begin
          we_q[wp_q] <= cpu.req_we;
          wp_q       <= ptr_inc(wp_q);
        end
        if (gnt_oh[gi]) begin
          rp_q <= ptr_inc(rp_q);
        end
      end
    end

    assign is_store[gi] = we_q[rp_q];
  end

  assign cand     = {err_full_q, slv.resp_valid};
  assign can_load = ~resp_valid_q | cpu.resp_ready[0];

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    arb_idx = 0;
    for (int k = 0; k < NCAND; k++) begin
      arb_idx = int'(rr_q) + k;
      if (arb_idx >= NCAND) arb_idx = arb_idx - NCAND;
      if (!gnt_any && cand[arb_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = RR_W'(arb_idx);
      end
    end
    if (!(active && can_load)) gnt_any = 1'b0;
  end

  always_comb begin
    gnt_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  assign slv.resp_ready = gnt_oh[NUM_SLV-1:0];

  // Default selection is the decode-error slot; a granted slave overrides it.
  // Slaves may also flag an error of their own, which is passed through.
  always_comb begin
    sel_rdata = '0;
    sel_tag   = err_tag_q;
    sel_err   = 1'b1;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (gnt_oh[i]) begin
        sel_tag   = slv.resp_tag[i*TAG_W +: TAG_W];
        sel_err   = slv.resp_err[i];
        sel_rdata = (is_store[i] || slv.resp_err[i]) ? '0 : slv.resp_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    err_full_d   = err_full_q;
    err_tag_d    = err_tag_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;

    if (gnt_any) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = sel_rdata;
      resp_tag_d   = sel_tag;
      resp_err_d   = sel_err;
      rr_d         = (gnt_idx == ERR_IDX) ? '0 : gnt_idx + 1'b1;
    end else if (resp_hs) begin
      resp_valid_d = 1'b0;
    end

    if (req_hs && !hit_any) begin
      err_full_d = 1'b1;
      err_tag_d  = cpu.req_tag;
    end else if (gnt_oh[NUM_SLV]) begin
      err_full_d = 1'b0;
    end

    if (req_hs && !resp_hs)      cnt_d = cnt_q + 1'b1;
    else if (!req_hs && resp_hs) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q        <= 1'b0;
      cnt_q        <= '0;
      rr_q         <= '0;
      err_full_q   <= 1'b0;
      err_tag_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      err_full_q   <= err_full_d;
      err_tag_q    <= err_tag_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign cpu.resp_tag   = resp_tag_q;
  assign cpu.resp_err   = resp_err_q;
endmodule
